// File: rtl/accelerator_vector_multimode_engine.sv
// Streaming vector engine: dot product or element-wise mul/add/sub of two signed vectors.
// Define ACCELERATOR_VECTOR_MULTIMODE_SATURATION_EN for signed saturation with a sticky OVERFLOW flag.
module accelerator_vector_multimode_engine #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  output logic                    READY,
  input  logic [CONTROL_SIZE-1:0] MODE,
  output logic                    DATA_IN_READY,
  input  logic                    DATA_A_IN_ENABLE,
  input  logic                    DATA_B_IN_ENABLE,
  output logic                    DATA_OUT_ENABLE,
  output logic                    OVERFLOW,
  input  logic [DATA_SIZE-1:0]    LENGTH_IN,
  input  logic [DATA_SIZE-1:0]    DATA_A_IN,
  input  logic [DATA_SIZE-1:0]    DATA_B_IN,
  output logic [DATA_SIZE-1:0]    DATA_OUT
);

  typedef enum logic [2:0] {
    ST_STARTER   = 3'd0,
    ST_INPUT     = 3'd1,
    ST_OPERATION = 3'd2,
    ST_UPDATE    = 3'd3,
    ST_ENDER     = 3'd4
  } state_t;

  localparam logic [1:0] MODE_DOT = 2'd0;
  localparam logic [1:0] MODE_ADD = 2'd2;
  localparam logic [1:0] MODE_SUB = 2'd3;

  localparam logic [DATA_SIZE-1:0] ZERO_W = {DATA_SIZE{1'b0}};
  localparam logic [DATA_SIZE-1:0] ONE_W  = {{(DATA_SIZE-1){1'b0}}, 1'b1};

  state_t                state_r;
  logic [1:0]            mode_r;
  logic [DATA_SIZE-1:0]  length_r;
  logic [DATA_SIZE-1:0]  index_r;
  logic [DATA_SIZE-1:0]  acc_r;
  logic [DATA_SIZE-1:0]  a_r;
  logic [DATA_SIZE-1:0]  b_r;
  logic                  a_full_r;
  logic                  b_full_r;
  logic [DATA_SIZE-1:0]  result_r;
  logic                  ready_r;
  logic                  data_out_enable_r;
  logic [DATA_SIZE-1:0]  data_out_r;
  logic                  overflow_r;

  logic [DATA_SIZE-1:0]  r_s;
  logic [DATA_SIZE-1:0]  acc_next_s;
  logic                  step_ovf_s;

  // Only MODE[1:0] selects the operation; the upper bits are deliberately ignored.
  logic unused_mode_bits_s;
  assign unused_mode_bits_s = ^MODE[CONTROL_SIZE-1:2];

`ifdef ACCELERATOR_VECTOR_MULTIMODE_SATURATION_EN
  function automatic logic [DATA_SIZE-1:0] sat_limit(input logic negative);
    sat_limit = negative ? {1'b1, {(DATA_SIZE-1){1'b0}}} : {1'b0, {(DATA_SIZE-1){1'b1}}};
  endfunction

  logic signed [2*DATA_SIZE-1:0] prod_full_s;
  logic [DATA_SIZE:0]            prod_top_s;
  logic [DATA_SIZE:0]            sum_ext_s;
  logic [DATA_SIZE:0]            diff_ext_s;
  logic [DATA_SIZE:0]            acc_ext_s;
  logic                          prod_clip_s;
  logic                          r_clip_s;
  logic                          acc_clip_s;

  // Saturating datapath: the product is in range only if its top DATA_SIZE+1 bits agree.
  always_comb begin
    prod_full_s = $signed({{DATA_SIZE{a_r[DATA_SIZE-1]}}, a_r})
                * $signed({{DATA_SIZE{b_r[DATA_SIZE-1]}}, b_r});
    prod_top_s  = prod_full_s[2*DATA_SIZE-1:DATA_SIZE-1];
    prod_clip_s = !((&prod_top_s) || !(|prod_top_s));
    sum_ext_s   = {a_r[DATA_SIZE-1], a_r} + {b_r[DATA_SIZE-1], b_r};
    diff_ext_s  = {a_r[DATA_SIZE-1], a_r} - {b_r[DATA_SIZE-1], b_r};
    case (mode_r)
      MODE_ADD: begin
        r_clip_s = sum_ext_s[DATA_SIZE] ^ sum_ext_s[DATA_SIZE-1];
        r_s      = r_clip_s ? sat_limit(sum_ext_s[DATA_SIZE]) : sum_ext_s[DATA_SIZE-1:0];
      end
      MODE_SUB: begin
        r_clip_s = diff_ext_s[DATA_SIZE] ^ diff_ext_s[DATA_SIZE-1];
        r_s      = r_clip_s ? sat_limit(diff_ext_s[DATA_SIZE]) : diff_ext_s[DATA_SIZE-1:0];
      end
      default: begin
        r_clip_s = prod_clip_s;
        r_s      = r_clip_s ? sat_limit(prod_full_s[2*DATA_SIZE-1]) : prod_full_s[DATA_SIZE-1:0];
      end
    endcase
    acc_ext_s  = {acc_r[DATA_SIZE-1], acc_r} + {r_s[DATA_SIZE-1], r_s};
    acc_clip_s = (mode_r == MODE_DOT) && (acc_ext_s[DATA_SIZE] ^ acc_ext_s[DATA_SIZE-1]);
    acc_next_s = (acc_ext_s[DATA_SIZE] ^ acc_ext_s[DATA_SIZE-1])
               ? sat_limit(acc_ext_s[DATA_SIZE]) : acc_ext_s[DATA_SIZE-1:0];
    step_ovf_s = r_clip_s || acc_clip_s;
  end
`else
  // Modular datapath: results and accumulator wrap at DATA_SIZE bits.
  always_comb begin
    case (mode_r)
      MODE_ADD: r_s = a_r + b_r;
      MODE_SUB: r_s = a_r - b_r;
      default:  r_s = a_r * b_r;
    endcase
    acc_next_s = acc_r + r_s;
    step_ovf_s = 1'b0;
  end
`endif

  // Control FSM with all outputs registered.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r           <= ST_STARTER;
      mode_r            <= 2'd0;
      length_r          <= ZERO_W;
      index_r           <= ZERO_W;
      acc_r             <= ZERO_W;
      a_r               <= ZERO_W;
      b_r               <= ZERO_W;
      a_full_r          <= 1'b0;
      b_full_r          <= 1'b0;
      result_r          <= ZERO_W;
      ready_r           <= 1'b0;
      data_out_enable_r <= 1'b0;
      data_out_r        <= ZERO_W;
      overflow_r        <= 1'b0;
    end else begin
      ready_r           <= 1'b0;
      data_out_enable_r <= 1'b0;
      case (state_r)
        ST_STARTER: begin
          if (START) begin
            mode_r     <= MODE[1:0];
            length_r   <= LENGTH_IN;
            index_r    <= ZERO_W;
            acc_r      <= ZERO_W;
            overflow_r <= 1'b0;
            a_full_r   <= 1'b0;
            b_full_r   <= 1'b0;
            state_r    <= (LENGTH_IN == ZERO_W) ? ST_ENDER : ST_INPUT;
          end
        end
        ST_INPUT: begin
          if (DATA_A_IN_ENABLE && !a_full_r) begin
            a_r      <= DATA_A_IN;
            a_full_r <= 1'b1;
          end
          if (DATA_B_IN_ENABLE && !b_full_r) begin
            b_r      <= DATA_B_IN;
            b_full_r <= 1'b1;
          end
          if ((a_full_r || DATA_A_IN_ENABLE) && (b_full_r || DATA_B_IN_ENABLE)) begin
            state_r <= ST_OPERATION;
          end
        end
        ST_OPERATION: begin
          result_r   <= r_s;
          overflow_r <= overflow_r | step_ovf_s;
          if (mode_r == MODE_DOT) begin
            acc_r <= acc_next_s;
          end
          a_full_r <= 1'b0;
          b_full_r <= 1'b0;
          state_r  <= ST_UPDATE;
        end
        ST_UPDATE: begin
          if (mode_r != MODE_DOT) begin
            data_out_r        <= result_r;
            data_out_enable_r <= 1'b1;
          end
          index_r <= index_r + ONE_W;
          state_r <= (index_r == length_r - ONE_W) ? ST_ENDER : ST_INPUT;
        end
        ST_ENDER: begin
          ready_r <= 1'b1;
          if (mode_r == MODE_DOT) begin
            data_out_r        <= acc_r;
            data_out_enable_r <= 1'b1;
          end
          state_r <= ST_STARTER;
        end
        default: begin
          state_r <= ST_STARTER;
        end
      endcase
    end
  end

  assign READY           = ready_r;
  assign DATA_OUT_ENABLE = data_out_enable_r;
  assign DATA_OUT        = data_out_r;
  assign OVERFLOW        = overflow_r;
  assign DATA_IN_READY   = (state_r == ST_INPUT);

endmodule

// File: tb/tb_accelerator_vector_multimode_engine.sv
// Directed bench for accelerator_vector_multimode_engine: vector table plus hand-written corner sequences.
module tb_accelerator_vector_multimode_engine;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic [3:0]  MODE;
  logic        DATA_A_IN_ENABLE, DATA_B_IN_ENABLE;
  logic [63:0] LENGTH_IN, DATA_A_IN, DATA_B_IN;
  logic        READY, DATA_IN_READY, DATA_OUT_ENABLE, OVERFLOW;
  logic [63:0] DATA_OUT;

  logic        s_start, s_a_en, s_b_en;
  logic [3:0]  s_mode;
  logic [7:0]  s_len, s_a, s_b, s_dout;
  logic        s_ready, s_dir, s_doe, s_ovf;

  always #5 CLK = ~CLK;

  accelerator_vector_multimode_engine #(.DATA_SIZE(64), .CONTROL_SIZE(4)) dut (
    .CLK(CLK), .RST(RST), .START(START), .READY(READY), .MODE(MODE),
    .DATA_IN_READY(DATA_IN_READY), .DATA_A_IN_ENABLE(DATA_A_IN_ENABLE),
    .DATA_B_IN_ENABLE(DATA_B_IN_ENABLE), .DATA_OUT_ENABLE(DATA_OUT_ENABLE),
    .OVERFLOW(OVERFLOW), .LENGTH_IN(LENGTH_IN), .DATA_A_IN(DATA_A_IN),
    .DATA_B_IN(DATA_B_IN), .DATA_OUT(DATA_OUT)
  );

  accelerator_vector_multimode_engine #(.DATA_SIZE(8), .CONTROL_SIZE(4)) dut8 (
    .CLK(CLK), .RST(RST), .START(s_start), .READY(s_ready), .MODE(s_mode),
    .DATA_IN_READY(s_dir), .DATA_A_IN_ENABLE(s_a_en), .DATA_B_IN_ENABLE(s_b_en),
    .DATA_OUT_ENABLE(s_doe), .OVERFLOW(s_ovf), .LENGTH_IN(s_len),
    .DATA_A_IN(s_a), .DATA_B_IN(s_b), .DATA_OUT(s_dout)
  );

  typedef struct packed {
    logic [3:0]       mode;
    logic [2:0]       len;
    logic [2:0][63:0] a;
    logic [2:0][63:0] b;
    logic [2:0][63:0] exp;
  } vec_t;

  vec_t        vt[7];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [63:0] out_q[$];
  int          out_cyc_q[$];
  int          rdy_cnt = 0;
  int          rdy_cyc = 0;
  logic        rdy_with_doe = 1'b0;
  logic        dir_seen = 1'b0;
  int          caps[3];

  always @(posedge CLK) cyc <= cyc + 1;

  // Pulse monitor, sampled on the falling edge.
  always @(negedge CLK) begin
    if (DATA_OUT_ENABLE) begin
      out_q.push_back(DATA_OUT);
      out_cyc_q.push_back(cyc);
    end
    if (READY) begin
      rdy_cnt++;
      rdy_cyc = cyc;
      rdy_with_doe = DATA_OUT_ENABLE;
    end
    if (DATA_IN_READY) dir_seen = 1'b1;
  end

  function automatic vec_t mk(input logic [3:0] m, input logic [2:0] n,
                              input longint a0, a1, a2, b0, b1, b2, e0, e1, e2);
    mk.mode = m;
    mk.len  = n;
    mk.a    = {a2, a1, a0};
    mk.b    = {b2, b1, b0};
    mk.exp  = {e2, e1, e0};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h)", name, $signed(act), act, $signed(exp), exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_dir(input string name);
    int n = 0;
    while (!DATA_IN_READY && n < 20) begin
      step();
      n++;
    end
    check({name, " data_in_ready"}, {63'd0, DATA_IN_READY}, 64'd1);
  endtask

  task automatic start_op(input logic [3:0] m, input logic [63:0] len);
    out_q.delete();
    out_cyc_q.delete();
    rdy_cnt = 0;
    dir_seen = 1'b0;
    MODE = m;
    LENGTH_IN = len;
    START = 1'b1;
    step();
    START = 1'b0;
    MODE = 4'hF;
    LENGTH_IN = 64'd7;
  endtask

  task automatic feed(input logic [63:0] a, input logic [63:0] b, output int cap);
    wait_dir("feed");
    DATA_A_IN = a;
    DATA_B_IN = b;
    DATA_A_IN_ENABLE = 1'b1;
    DATA_B_IN_ENABLE = 1'b1;
    step();
    cap = cyc;
    DATA_A_IN_ENABLE = 1'b0;
    DATA_B_IN_ENABLE = 1'b0;
  endtask

  task automatic finish_op(input string name);
    int n = 0;
    while (rdy_cnt == 0 && n < 30) begin
      step();
      n++;
    end
    repeat (3) step();
    check({name, " ready pulses"}, 64'(rdy_cnt), 64'd1);
  endtask

  initial begin
    int cap;
    int st;
    int ln;
    logic [7:0] got8;
    logic       ovf8;

    vt[0] = mk(4'd0, 3'd3, 1, 2, 3, 4, 5, 6, 32, 0, 0);
    vt[1] = mk(4'd1, 3'd2, 3, -2, 0, 7, 5, 0, 21, -10, 0);
    vt[2] = mk(4'h6, 3'd3, 5, -7, 100, 6, 3, -200, 11, -4, -100);
    vt[3] = mk(4'd3, 3'd2, 0, -1, 0, 1, -1, 0, -1, 0, 0);
    vt[4] = mk(4'd0, 3'd2, -3, 1000, 0, 4, -2, 0, -2012, 0, 0);
    vt[5] = mk(4'hD, 3'd1, -6, 0, 0, -7, 0, 0, 42, 0, 0);
    vt[6] = mk(4'd3, 3'd3, 1000000, -5, 7, -1000000, -5, 9, 2000000, 0, -2);

    RST = 1'b1; START = 1'b0; MODE = 4'd0; LENGTH_IN = 64'd0;
    DATA_A_IN = 64'd0; DATA_B_IN = 64'd0; DATA_A_IN_ENABLE = 1'b0; DATA_B_IN_ENABLE = 1'b0;
    s_start = 1'b0; s_mode = 4'd0; s_len = 8'd0; s_a = 8'd0; s_b = 8'd0; s_a_en = 1'b0; s_b_en = 1'b0;
    #1;
    check("reset READY", {63'd0, READY}, 64'd0);
    check("reset DATA_OUT_ENABLE", {63'd0, DATA_OUT_ENABLE}, 64'd0);
    check("reset DATA_OUT", DATA_OUT, 64'd0);
    check("reset OVERFLOW", {63'd0, OVERFLOW}, 64'd0);
    check("reset DATA_IN_READY", {63'd0, DATA_IN_READY}, 64'd0);
    step();
    step();
    RST = 1'b0;
    step();

    // Table: both operands presented in the same cycle.
    for (int v = 0; v < 7; v++) begin
      ln = int'(vt[v].len);
      start_op(vt[v].mode, 64'(vt[v].len));
      for (int e = 0; e < ln; e++) begin
        feed(vt[v].a[e], vt[v].b[e], cap);
        caps[e] = cap;
      end
      finish_op($sformatf("vec%0d", v));
      check($sformatf("vec%0d ready cycle", v), 64'(rdy_cyc), 64'(caps[ln-1] + 3));
      check($sformatf("vec%0d overflow", v), {63'd0, OVERFLOW}, 64'd0);
      if (vt[v].mode[1:0] == 2'd0) begin
        check($sformatf("vec%0d dot pulses", v), 64'(out_q.size()), 64'd1);
        check($sformatf("vec%0d dot with ready", v), {63'd0, rdy_with_doe}, 64'd1);
        if (out_q.size() > 0) begin
          check($sformatf("vec%0d dot value", v), out_q[0], vt[v].exp[0]);
          check($sformatf("vec%0d dot cycle", v), 64'(out_cyc_q[0]), 64'(caps[ln-1] + 3));
        end
      end else begin
        check($sformatf("vec%0d elem pulses", v), 64'(out_q.size()), 64'(ln));
        check($sformatf("vec%0d ready alone", v), {63'd0, rdy_with_doe}, 64'd0);
        for (int e = 0; e < ln; e++) begin
          if (e < out_q.size()) begin
            check($sformatf("vec%0d elem%0d value", v, e), out_q[e], vt[v].exp[e]);
            check($sformatf("vec%0d elem%0d cycle", v, e), 64'(out_cyc_q[e]), 64'(caps[e] + 2));
          end
        end
      end
    end

    // B issued one cycle ahead of A for each element.
    start_op(4'd1, 64'd2);
    for (int e = 0; e < 2; e++) begin
      wait_dir("bfirst");
      DATA_B_IN = (e == 0) ? 64'd7 : 64'd5;
      DATA_B_IN_ENABLE = 1'b1;
      step();
      DATA_B_IN_ENABLE = 1'b0;
      DATA_A_IN = (e == 0) ? 64'd3 : -64'sd2;
      DATA_A_IN_ENABLE = 1'b1;
      step();
      caps[e] = cyc;
      DATA_A_IN_ENABLE = 1'b0;
    end
    finish_op("bfirst");
    check("bfirst pulses", 64'(out_q.size()), 64'd2);
    if (out_q.size() == 2) begin
      check("bfirst v0", out_q[0], 64'd21);
      check("bfirst v1", out_q[1], -64'sd10);
      check("bfirst c0", 64'(out_cyc_q[0]), 64'(caps[0] + 2));
      check("bfirst c1", 64'(out_cyc_q[1]), 64'(caps[1] + 2));
      check("bfirst ready cycle", 64'(rdy_cyc), 64'(out_cyc_q[1] + 1));
    end

    // A enable repeated while the A slot is full; the second value must be ignored.
    start_op(4'd3, 64'd1);
    wait_dir("dupA");
    DATA_A_IN = 64'd10;
    DATA_A_IN_ENABLE = 1'b1;
    step();
    DATA_A_IN = 64'd99;
    step();
    DATA_A_IN_ENABLE = 1'b0;
    DATA_B_IN = 64'd25;
    DATA_B_IN_ENABLE = 1'b1;
    step();
    cap = cyc;
    DATA_B_IN_ENABLE = 1'b0;
    finish_op("dupA");
    check("dupA pulses", 64'(out_q.size()), 64'd1);
    if (out_q.size() > 0) begin
      check("dupA value", out_q[0], -64'sd15);
      check("dupA cycle", 64'(out_cyc_q[0]), 64'(cap + 2));
    end

    // Reset in INPUT after one of three elements aborts with no output.
    start_op(4'd0, 64'd3);
    feed(64'd5, 64'd5, cap);
    wait_dir("abort");
    RST = 1'b1;
    #1;
    check("abort READY", {63'd0, READY}, 64'd0);
    check("abort DATA_OUT_ENABLE", {63'd0, DATA_OUT_ENABLE}, 64'd0);
    check("abort DATA_OUT", DATA_OUT, 64'd0);
    check("abort OVERFLOW", {63'd0, OVERFLOW}, 64'd0);
    check("abort DATA_IN_READY", {63'd0, DATA_IN_READY}, 64'd0);
    step();
    RST = 1'b0;
    step();
    check("abort no pulses", 64'(out_q.size() + rdy_cnt), 64'd0);
    start_op(4'd0, 64'd1);
    feed(64'd2, 64'd2, cap);
    finish_op("after abort");
    check("after abort pulses", 64'(out_q.size()), 64'd1);
    if (out_q.size() > 0) check("after abort value", out_q[0], 64'd4);

    // Zero-length dot product.
    start_op(4'd0, 64'd0);
    st = cyc;
    finish_op("len0");
    check("len0 ready cycle", 64'(rdy_cyc), 64'(st + 1));
    check("len0 pulses", 64'(out_q.size()), 64'd1);
    check("len0 with ready", {63'd0, rdy_with_doe}, 64'd1);
    if (out_q.size() > 0) check("len0 value", out_q[0], 64'd0);
    check("len0 no data_in_ready", {63'd0, dir_seen}, 64'd0);

    // 8-bit add 100 + 100 at the signed boundary.
    s_mode = 4'd2;
    s_len = 8'd1;
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    for (int n = 0; n < 20 && !s_dir; n++) step();
    check("w8 data_in_ready", {63'd0, s_dir}, 64'd1);
    s_a = 8'd100;
    s_b = 8'd100;
    s_a_en = 1'b1;
    s_b_en = 1'b1;
    step();
    s_a_en = 1'b0;
    s_b_en = 1'b0;
    for (int n = 0; n < 20 && !s_doe; n++) step();
    check("w8 pulse", {63'd0, s_doe}, 64'd1);
    got8 = s_dout;
    step();
    ovf8 = s_ovf;
`ifdef ACCELERATOR_VECTOR_MULTIMODE_SATURATION_EN
    check("w8 add value", {56'd0, got8}, 64'd127);
    check("w8 overflow", {63'd0, ovf8}, 64'd1);
`else
    check("w8 add value", {56'd0, got8}, 64'hC8);
    check("w8 overflow", {63'd0, ovf8}, 64'd0);
`endif
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/accelerator_vector_multimode_engine.md
Name: accelerator_vector_multimode_engine

Overview:
- Parametrised successor to the single-mode vector dot-product block.
- Streams two signed integer vectors element by element under per-operand enables.
- Computes, selected by MODE: dot product, element-wise product, element-wise sum or element-wise difference.
- Sits in the algebra/vector layer. Upstream feeds it from memory controllers; downstream is an NTM addressing/controller stage.

Parameters:
- DATA_SIZE, 64, element, accumulator and length width (two's complement).
- CONTROL_SIZE, 4, width of MODE; only MODE[1:0] is decoded.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- START  in  1  begin operation; sampled only in STARTER.
- READY  out  1  one-cycle pulse at end of operation.
- MODE  in  CONTROL_SIZE  latched at START: 0 dot, 1 mul, 2 add, 3 sub (a-b).
- DATA_IN_READY  out  1  high in INPUT state only.
- DATA_A_IN_ENABLE  in  1  DATA_A_IN valid this cycle.
- DATA_B_IN_ENABLE  in  1  DATA_B_IN valid this cycle.
- DATA_OUT_ENABLE  out  1  one-cycle pulse, DATA_OUT valid.
- OVERFLOW  out  1  sticky saturation flag (see Optional Feature).
- LENGTH_IN  in  DATA_SIZE  element count, latched at START.
- DATA_A_IN  in  DATA_SIZE  element of vector A.
- DATA_B_IN  in  DATA_SIZE  element of vector B.
- DATA_OUT  out  DATA_SIZE  result element or dot product.

Behaviour:
- Reset: one clock (CLK); asynchronous, active-high reset (RST).
  - RST high forces state STARTER immediately.
  - Clears READY, DATA_OUT_ENABLE, OVERFLOW, DATA_OUT, index, accumulator and A/B full flags.
  - Reset mid-operation aborts with no output.
- Registered FSM, states STARTER=0, INPUT=1, OPERATION=2, UPDATE=3, ENDER=4. Illegal state goes to STARTER.
- STARTER:
  - READY and DATA_OUT_ENABLE are 0.
  - On START=1: latch MODE and LENGTH_IN; index=0, acc=0, OVERFLOW=0.
  - Go to ENDER if LENGTH_IN==0, else INPUT.
- INPUT:
  - DATA_A_IN_ENABLE captures DATA_A_IN into the A slot if empty; if the slot is already full the enable is ignored and the held value kept. B behaves identically.
  - A and B may arrive in the same or different cycles, in either order.
  - On the edge where both slots become full, go to OPERATION.
- OPERATION:
  - Compute r = a*b (low DATA_SIZE bits of the 2*DATA_SIZE product), a+b or a-b per MODE; dot uses the product.
  - Dot mode: acc <= acc + r (mod 2^DATA_SIZE).
  - Clear both full flags; go to UPDATE.
- UPDATE:
  - Modes 1-3: DATA_OUT=r and DATA_OUT_ENABLE=1 for this one cycle.
  - Index increments. If index==LENGTH-1 go to ENDER, else INPUT.
- ENDER:
  - READY=1 for one cycle.
  - Dot mode: also DATA_OUT=acc and DATA_OUT_ENABLE=1 (acc=0 when LENGTH was 0).
  - Go to STARTER.
- Latency, with the second operand captured at edge E:
  - Element result visible after edge E+2.
  - For the last element, READY (plus dot result) visible after edge E+3.
- Enables outside INPUT are dropped. START outside STARTER is ignored.
- DATA_OUT holds its last value between pulses.

Optional Feature:
- Macro ACCELERATOR_VECTOR_MULTIMODE_SATURATION_EN.
- Defined:
  - Every result r and every accumulator update saturates to the signed range [-2^(DATA_SIZE-1), 2^(DATA_SIZE-1)-1].
  - For products this includes high-half overflow.
  - Any clip sets OVERFLOW, which stays set until the next accepted START or reset.
- Undefined: modular wrap; OVERFLOW tied 0.

Test Plan:
- DATA_SIZE=64, MODE=0, LENGTH=3, A={1,2,3}, B={4,5,6}, enables same cycle -> READY and DATA_OUT_ENABLE pulse once together, DATA_OUT=32, exactly 3 edges after the last capture.
- MODE=1, LENGTH=2, A={3,-2}, B={7,5}, B issued one cycle before A each element -> two DATA_OUT_ENABLE pulses, 21 then -10, each 2 edges after the pair completes; READY 1 edge after the second.
- MODE=3, LENGTH=1, A=10, B=25; DATA_A_IN_ENABLE asserted twice (10 then 99) before B -> DATA_OUT=-15 (second A ignored).
- MODE=0, LENGTH=0, START -> READY and DATA_OUT_ENABLE after 2 edges, DATA_OUT=0; DATA_IN_READY never high.
- DATA_SIZE=8, MODE=2, A=100, B=100 -> without macro DATA_OUT=-56 (0xC8), OVERFLOW=0; with macro DATA_OUT=127, OVERFLOW=1.
- RST pulsed while in INPUT after 1 of 3 elements -> all outputs 0 immediately, state STARTER; a new START with MODE=0, LENGTH=1, A=2, B=2 -> DATA_OUT=4.
